ccw_sequencer: RTL and testbench

Upstream stage of `channel`: executes a host-loaded list of channel command words (CCWs) against one device address. Each CCW is presented to `channel` through its address/command/count/start_strobe interface. The sequencer collects the ending status and residual count, then follows command chaining until the list ends or an exception stops it. The result is a channel status word (CSW) for the host.

---
 rtl/ccw_sequencer.sv | 231 +++++++++++++++++++++++
 tb/tb_ccw_sequencer.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ccw_sequencer.sv
// ccw_sequencer: walks a host-loaded channel command word (CCW) list against one
// device address. Each CCW is handed to the downstream channel. The ending status
// and residual count are collected. Command chaining continues until the list ends
// or an exception stops it. The result is reported as a channel status word (CSW).
//
// Optional build macro CCW_SEQUENCER_BUSY_RETRY_EN: when defined, a busy status
// re-issues the same CCW up to BUSY_RETRIES times before terminating.
module ccw_sequencer #(
    parameter int DEPTH_LOG2   = 4,
    parameter int BUSY_RETRIES = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ccw_wr_en,
    input  logic [DEPTH_LOG2-1:0] ccw_wr_addr,
    input  logic [23:0]           ccw_wr_data,
    input  logic [7:0]            device_address,
    input  logic                  go,
    input  logic                  abort,
    output logic                  busy,
    output logic                  done,
    output logic [7:0]            csw_status,
    output logic [7:0]            csw_res_count,
    output logic [DEPTH_LOG2-1:0] csw_index,
    output logic                  csw_incorrect_length,
    output logic                  csw_program_check,
    output logic                  csw_aborted,
    output logic [7:0]            address,
    output logic [7:0]            command,
    output logic [7:0]            count,
    output logic                  start_strobe,
    input  logic                  chan_complete,
    input  logic [7:0]            chan_status,
    input  logic [7:0]            chan_res_count
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] LAST_INDEX = {1'b0, {DEPTH_LOG2{1'b1}}};
    localparam logic [DEPTH_LOG2:0] IDX_ONE    = (DEPTH_LOG2 + 1)'(1);
    localparam logic [DEPTH_LOG2:0] IDX_TWO    = (DEPTH_LOG2 + 1)'(2);
    localparam logic [7:0] ST_SM   = 8'h40;
    localparam logic [7:0] ST_BUSY = 8'h10;
    localparam logic [7:0] ST_UC   = 8'h02;
    localparam logic [7:0] ST_UE   = 8'h01;
    localparam logic [7:0] CMD_NOP = 8'h03;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_ISSUE,
        S_WAIT,
        S_EVAL,
        S_FINISH
    } state_t;

    state_t state_reg, state_next;

    logic [23:0]           ccw_mem [DEPTH];
    logic [23:0]           ccw_rd_reg;
    logic [DEPTH_LOG2-1:0] index_reg, index_next;
    logic [DEPTH_LOG2:0]   chain_wide;
    logic [7:0]            address_reg;
    logic [7:0]            stat_reg;
    logic [7:0]            res_reg;
    logic                  abort_seen_reg;
    logic [7:0]            csw_status_reg;
    logic [7:0]            csw_res_count_reg;
    logic [DEPTH_LOG2-1:0] csw_index_reg;
    logic                  csw_il_reg;
    logic                  csw_pc_reg;
    logic                  csw_ab_reg;
    logic                  set_il, set_pc, set_ab;

    // Fields of the CCW currently held in the read register
    logic [7:0] cur_cmd;
    logic       cur_cc;
    logic       cur_sli;
    logic       unused_flags;

    assign cur_cmd      = ccw_rd_reg[23:16];
    assign cur_cc       = ccw_rd_reg[14];
    assign cur_sli      = ccw_rd_reg[13];
    assign unused_flags = ^{ccw_rd_reg[15], ccw_rd_reg[12:8]};

    // Status-modifier skips one extra entry when chaining
    assign chain_wide = {1'b0, index_reg} + (((stat_reg & ST_SM) != 8'h00) ? IDX_TWO : IDX_ONE);

`ifdef CCW_SEQUENCER_BUSY_RETRY_EN
    localparam int RW = (BUSY_RETRIES < 1) ? 1 : $clog2(BUSY_RETRIES + 1);
    logic [RW-1:0] retry_cnt_reg;
    logic          retry_ok;

    assign retry_ok = (int'(retry_cnt_reg) < BUSY_RETRIES);

    // Retry counter: cleared whenever a new index is fetched, bumped on each re-issue
    always_ff @(posedge clk) begin
        if (reset) begin
            retry_cnt_reg <= '0;
        end else if (state_reg == S_FETCH) begin
            retry_cnt_reg <= '0;
        end else if (state_reg == S_EVAL && state_next == S_ISSUE) begin
            retry_cnt_reg <= retry_cnt_reg + RW'(1);
        end
    end
`endif

    // CCW list write port; the host cannot disturb a list that is being executed
    always_ff @(posedge clk) begin
        if (ccw_wr_en && !busy) begin
            ccw_mem[ccw_wr_addr] <= ccw_wr_data;
        end
    end

    // Registered list read during FETCH; this register also drives command/count
    always_ff @(posedge clk) begin
        if (reset) begin
            ccw_rd_reg <= '0;
        end else if (state_reg == S_FETCH) begin
            ccw_rd_reg <= ccw_mem[index_reg];
        end
    end

    // Next-state and termination decision
    always_comb begin
        state_next = state_reg;
        index_next = index_reg;
        set_il     = 1'b0;
        set_pc     = 1'b0;
        set_ab     = 1'b0;
        unique case (state_reg)
            S_IDLE: begin
                if (go) begin
                    state_next = S_FETCH;
                    index_next = '0;
                end
            end
            S_FETCH: state_next = S_ISSUE;
            S_ISSUE: state_next = S_WAIT;
            S_WAIT: begin
                if (chan_complete) begin
                    state_next = S_EVAL;
                end
            end
            S_EVAL: begin
                state_next = S_FINISH;
                if ((stat_reg & ST_BUSY) != 8'h00) begin
`ifdef CCW_SEQUENCER_BUSY_RETRY_EN
                    if (retry_ok) begin
                        state_next = S_ISSUE;
                    end
`endif
                end else if ((stat_reg & (ST_UC | ST_UE)) != 8'h00) begin
                    // unit check / exception: terminate with status only
                end else if (res_reg != 8'h00 && !cur_sli && cur_cmd != CMD_NOP) begin
                    set_il = 1'b1;
                end else if (abort_seen_reg) begin
                    set_ab = 1'b1;
                end else if (cur_cc) begin
                    if (chain_wide > LAST_INDEX) begin
                        set_pc = 1'b1;
                    end else begin
                        index_next = chain_wide[DEPTH_LOG2-1:0];
                        state_next = S_FETCH;
                    end
                end
            end
            S_FINISH: state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
    end

    // State, index, captured channel result, abort latch and CSW registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg         <= S_IDLE;
            index_reg         <= '0;
            address_reg       <= '0;
            stat_reg          <= '0;
            res_reg           <= '0;
            abort_seen_reg    <= 1'b0;
            csw_status_reg    <= '0;
            csw_res_count_reg <= '0;
            csw_index_reg     <= '0;
            csw_il_reg        <= 1'b0;
            csw_pc_reg        <= 1'b0;
            csw_ab_reg        <= 1'b0;
        end else begin
            state_reg <= state_next;
            index_reg <= index_next;
            if (state_reg == S_IDLE && go) begin
                address_reg       <= device_address;
                abort_seen_reg    <= 1'b0;
                csw_status_reg    <= '0;
                csw_res_count_reg <= '0;
                csw_index_reg     <= '0;
                csw_il_reg        <= 1'b0;
                csw_pc_reg        <= 1'b0;
                csw_ab_reg        <= 1'b0;
            end else if (busy && abort) begin
                abort_seen_reg <= 1'b1;
            end
            if (state_reg == S_WAIT && chan_complete) begin
                stat_reg <= chan_status;
                res_reg  <= chan_res_count;
            end
            if (state_reg == S_EVAL) begin
                csw_status_reg    <= stat_reg;
                csw_res_count_reg <= res_reg;
                csw_index_reg     <= index_reg;
                if (set_il) csw_il_reg <= 1'b1;
                if (set_pc) csw_pc_reg <= 1'b1;
                if (set_ab) csw_ab_reg <= 1'b1;
            end
        end
    end

    assign busy                 = (state_reg == S_FETCH) || (state_reg == S_ISSUE) ||
                                  (state_reg == S_WAIT)  || (state_reg == S_EVAL);
    assign done                 = (state_reg == S_FINISH);
    assign start_strobe         = (state_reg == S_ISSUE);
    assign address              = address_reg;
    assign command              = ccw_rd_reg[23:16];
    assign count                = ccw_rd_reg[7:0];
    assign csw_status           = csw_status_reg;
    assign csw_res_count        = csw_res_count_reg;
    assign csw_index            = csw_index_reg;
    assign csw_incorrect_length = csw_il_reg;
    assign csw_program_check    = csw_pc_reg;
    assign csw_aborted          = csw_ab_reg;

endmodule

// File: tb/tb_ccw_sequencer.sv
// Self-checking bench for ccw_sequencer: a mock channel answers each start_strobe
// with a pre-drawn status/limit, and a list-walking reference model predicts the
// issued commands and the final CSW.
module tb_ccw_sequencer;

    localparam int DL = 4;
    localparam int BR = 3;
    localparam int NRESP = 64;

    logic          clk = 1'b0;
    logic          reset;
    logic          ccw_wr_en;
    logic [DL-1:0] ccw_wr_addr;
    logic [23:0]   ccw_wr_data;
    logic [7:0]    device_address;
    logic          go;
    logic          abort;
    logic          busy;
    logic          done;
    logic [7:0]    csw_status;
    logic [7:0]    csw_res_count;
    logic [DL-1:0] csw_index;
    logic          csw_incorrect_length;
    logic          csw_program_check;
    logic          csw_aborted;
    logic [7:0]    address;
    logic [7:0]    command;
    logic [7:0]    count;
    logic          start_strobe;
    logic          chan_complete;
    logic [7:0]    chan_status;
    logic [7:0]    chan_res_count;

    int n_checks = 0;
    int n_errors = 0;

    // Reference state: host copy of the list and per-issue mock responses
    logic [23:0] list_m [16];
    logic [7:0]  resp_st [NRESP];
    logic [7:0]  resp_lim [NRESP];
    logic [7:0]  exp_cmd [$];
    logic [7:0]  exp_cnt [$];
    logic [7:0]  e_status, e_res;
    int          e_index;
    bit          e_il, e_pc, e_ab;
    int          last_issues;

    ccw_sequencer #(.DEPTH_LOG2(DL), .BUSY_RETRIES(BR)) dut (
        .clk(clk), .reset(reset),
        .ccw_wr_en(ccw_wr_en), .ccw_wr_addr(ccw_wr_addr), .ccw_wr_data(ccw_wr_data),
        .device_address(device_address), .go(go), .abort(abort),
        .busy(busy), .done(done),
        .csw_status(csw_status), .csw_res_count(csw_res_count), .csw_index(csw_index),
        .csw_incorrect_length(csw_incorrect_length), .csw_program_check(csw_program_check),
        .csw_aborted(csw_aborted),
        .address(address), .command(command), .count(count), .start_strobe(start_strobe),
        .chan_complete(chan_complete), .chan_status(chan_status), .chan_res_count(chan_res_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] residual(input logic [7:0] cnt, input logic [7:0] lim);
        return (cnt > lim) ? cnt - lim : 8'h00;
    endfunction

    // Walk the list the way a channel program is defined to run
    task automatic model(input int abort_issue);
        int idx, k, tries, step;
        logic [23:0] e;
        logic [7:0] cmd, cnt, st, res;
        exp_cmd.delete();
        exp_cnt.delete();
        e_il = 0; e_pc = 0; e_ab = 0;
        idx = 0; k = 0; tries = 0;
        for (int guard = 0; guard < NRESP; guard++) begin
            e   = list_m[idx];
            cmd = e[23:16];
            cnt = e[7:0];
            exp_cmd.push_back(cmd);
            exp_cnt.push_back(cnt);
            st  = resp_st[k];
            res = residual(cnt, resp_lim[k]);
            e_status = st; e_res = res; e_index = idx;
            k++;
            if (st[4]) begin
`ifdef CCW_SEQUENCER_BUSY_RETRY_EN
                if (tries < BR) begin
                    tries++;
                    continue;
                end
`endif
                break;
            end
            if (st[1] || st[0]) break;
            if (res != 0 && !e[13] && cmd != 8'h03) begin e_il = 1; break; end
            if (k - 1 >= abort_issue) begin e_ab = 1; break; end
            if (!e[14]) break;
            step = st[6] ? 2 : 1;
            if (idx + step > 15) begin e_pc = 1; break; end
            idx += step;
            tries = 0;
        end
    endtask

    task automatic write_ccw(input int a, input logic [23:0] d);
        ccw_wr_en = 1'b1; ccw_wr_addr = DL'(a); ccw_wr_data = d;
        list_m[a] = d;
        @(posedge clk); #1;
        ccw_wr_en = 1'b0;
    endtask

    task automatic fill_list(input logic [23:0] d);
        for (int i = 0; i < 16; i++) write_ccw(i, d);
    endtask

    task automatic fill_resp(input logic [7:0] st, input logic [7:0] lim);
        for (int k = 0; k < NRESP; k++) begin resp_st[k] = st; resp_lim[k] = lim; end
    endtask

    // Start the list, play the channel, check every issue and the final CSW
    task automatic run_op(input int abort_issue);
        int cyc, n_iss, delay, last_cc;
        bit pending, fin, abort_now, prev_busy;
        logic [7:0] dev, p_st, p_res;
        model(abort_issue);
        dev = 8'($urandom);
        @(posedge clk); #1;
        device_address = dev;
        go = 1'b1;
        cyc = 0; n_iss = 0; delay = 0; last_cc = -100;
        pending = 0; fin = 0; abort_now = 0; prev_busy = 0;
        p_st = 0; p_res = 0;
        while (!fin && cyc < 2000) begin
            @(posedge clk); #1;
            cyc++;
            go = 1'b0; chan_complete = 1'b0; abort = 1'b0;
            chan_status = 8'($urandom); chan_res_count = 8'($urandom);
            ccw_wr_en = busy; ccw_wr_addr = DL'(cyc); ccw_wr_data = 24'($urandom);
            if (cyc == 1) check("busy_after_go", busy, 1);
            if (start_strobe) begin
                if (n_iss == 0) check("first_issue_cycle", cyc, 2);
                else check("next_issue_cycle", cyc - last_cc, prev_busy ? 2 : 3);
                check("issue_in_list", (n_iss < exp_cmd.size()), 1);
                if (n_iss < exp_cmd.size()) begin
                    check("issue_cmd", command, exp_cmd[n_iss]);
                    check("issue_count", count, exp_cnt[n_iss]);
                end
                check("issue_addr", address, dev);
                p_st = resp_st[n_iss % NRESP];
                p_res = residual(count, resp_lim[n_iss % NRESP]);
                abort_now = (n_iss == abort_issue);
                delay = 1 + $urandom_range(0, 3);
                pending = 1;
                n_iss++;
            end else if (pending) begin
                delay--;
                if (delay == 0) begin
                    chan_complete = 1'b1;
                    chan_status = p_st;
                    chan_res_count = p_res;
                    if (abort_now) abort = 1'b1;
                    pending = 0;
                    last_cc = cyc;
                    prev_busy = p_st[4];
                end
            end
            if (done) begin
                fin = 1;
                check("done_cycle", cyc - last_cc, 2);
                check("busy_at_done", busy, 0);
                check("issues", n_iss, exp_cmd.size());
                check("csw_status", csw_status, e_status);
                check("csw_res_count", csw_res_count, e_res);
                check("csw_index", csw_index, e_index);
                check("csw_flags", {csw_incorrect_length, csw_program_check, csw_aborted},
                      {e_il, e_pc, e_ab});
                $display("op: dev=%02h issues=%0d status=%02h res=%02h idx=%0d il=%0b pc=%0b ab=%0b",
                         dev, n_iss, csw_status, csw_res_count, csw_index,
                         csw_incorrect_length, csw_program_check, csw_aborted);
            end
        end
        check("op_terminated", fin, 1);
        ccw_wr_en = 1'b0; chan_complete = 1'b0; abort = 1'b0;
        last_issues = n_iss;
    endtask

    function automatic logic [47:0] all_outputs();
        return {busy, done, start_strobe, csw_status, csw_res_count, csw_index,
                csw_incorrect_length, csw_program_check, csw_aborted,
                address, command, count};
    endfunction

    initial begin
        reset = 1'b1; ccw_wr_en = 1'b0; ccw_wr_addr = '0; ccw_wr_data = '0;
        device_address = '0; go = 1'b0; abort = 1'b0;
        chan_complete = 1'b0; chan_status = '0; chan_res_count = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        check("reset_outputs", all_outputs(), 48'h0);

        // READ with SLI: residual reported, no incorrect length
        fill_list(24'h000000);
        write_ccw(0, 24'h022010);
        fill_resp(8'h0C, 8'd6);
        run_op(1000);
        check("t1_res", csw_res_count, 8'd10);
        check("t1_il", csw_incorrect_length, 0);
        check("t1_issues", last_issues, 1);

        // READ without SLI and CC set: incorrect length stops the chain
        write_ccw(0, 24'h024010);
        write_ccw(1, 24'h050001);
        run_op(1000);
        check("t2_il", csw_incorrect_length, 1);
        check("t2_issues", last_issues, 1);

        // Two-CCW chain
        write_ccw(0, 24'h014006);
        write_ccw(1, 24'h020006);
        fill_resp(8'h0C, 8'd16);
        run_op(1000);
        check("t3_index", csw_index, 1);
        check("t3_status", csw_status, 8'h0C);
        check("t3_issues", last_issues, 2);

        // Busy device
        write_ccw(0, 24'h020004);
        fill_resp(8'h10, 8'd255);
        run_op(1000);
`ifdef CCW_SEQUENCER_BUSY_RETRY_EN
        check("t4_issues", last_issues, BR + 1);
`else
        check("t4_issues", last_issues, 1);
`endif
        check("t4_busy_bit", csw_status[4], 1);

        // Chain running off the end of the list
        for (int i = 0; i < 16; i++) write_ccw(i, {8'(i + 1), 8'h40, 8'h01});
        fill_resp(8'h0C, 8'd255);
        run_op(1000);
        check("t5_pc", csw_program_check, 1);
        check("t5_issues", last_issues, 16);

        // Abort during WAIT of CCW0
        run_op(0);
        check("t6_ab", csw_aborted, 1);
        check("t6_index", csw_index, 0);

        // Reset in the middle of WAIT, then a normal run from the retained list
        @(posedge clk); #1;
        go = 1'b1; device_address = 8'h5A;
        @(posedge clk); #1; go = 1'b0;
        @(posedge clk); #1;
        check("t7_strobe", start_strobe, 1);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("t7_reset_outputs", all_outputs(), 48'h0);
        run_op(1000);
        check("t7_issues", last_issues, 16);

        // Randomized lists and channel responses
        for (int r = 0; r < 25; r++) begin
            for (int i = 0; i < 16; i++) begin
                logic [7:0] cmd, flg;
                cmd = ($urandom % 5 == 0) ? 8'h03 : 8'($urandom);
                flg = 8'($urandom);
                flg[6] = ($urandom % 4) != 0;
                flg[5] = $urandom % 2;
                write_ccw(i, {cmd, flg, 8'($urandom)});
            end
            for (int k = 0; k < NRESP; k++) begin
                case ($urandom % 8)
                    0, 1, 2: resp_st[k] = 8'h0C;
                    3, 4:    resp_st[k] = 8'h4C;
                    5:       resp_st[k] = 8'h10;
                    6:       resp_st[k] = 8'h0E;
                    default: resp_st[k] = 8'h0D;
                endcase
                resp_lim[k] = ($urandom % 2) ? 8'd255 : 8'($urandom);
            end
            run_op(($urandom % 4 == 0) ? $urandom_range(0, 5) : 1000);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
